// File: rtl/nf2401_pkg.sv
// Shared constants for the nRF2401 transmit shifter: register map, status bits, FSM states.
package nf2401_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_DONE  = 3;
    localparam int unsigned ST_OVF   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LO,
        S_HI,
        S_HOLD
    } state_t;

    // Largest of three timing parameters, used to size the shared timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nf2401_tx_shifter_if.sv
// Avalon-MM slave bus bundle for the nRF2401 transmit shifter.
interface nf2401_tx_shifter_if;

    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/nf2401_tx_fifo.sv
// Synchronous byte FIFO; a push at full succeeds when a pop happens in the same cycle.
module nf2401_tx_fifo #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [7:0]                 wdata,
    input  logic                       pop,
    output logic [7:0]                 rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/nf2401_tx_shifter.sv
// Avalon-MM slave that shifts FIFO bytes MSB-first onto the nRF2401 3-wire port.
module nf2401_tx_shifter
    import nf2401_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CLK_HALF   = 25,
    parameter int unsigned SETUP_CYC  = 250,
    parameter int unsigned HOLD_CYC   = 250
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nf2401_tx_shifter_if.slave   bus,
    output logic                 nrf_ce,
    output logic                 nrf_cs,
    output logic                 nrf_clk1,
    output logic                 nrf_data
);

    localparam int unsigned TW = $clog2(max3(CLK_HALF, SETUP_CYC, HOLD_CYC) + 1);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          mode;
    logic          irq_en;
    logic          done;
    logic          ovf;

    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;

    logic          wr_c;
    logic          wr_data_c;
    logic          wr_ctrl_c;
    logic          wr_clr_c;
    logic          start_c;
    logic          timer_zero_c;
    logic          fifo_pop_c;
    logic          done_set_c;
    logic          ovf_set_c;
    logic          busy_c;
    logic [7:0]    stat_c;

    assign wr_c         = bus.chipselect & ~bus.write_n;
    assign wr_data_c    = wr_c & (bus.address == ADDR_DATA);
    assign wr_ctrl_c    = wr_c & (bus.address == ADDR_CTRL);
    assign wr_clr_c     = wr_c & (bus.address == ADDR_CLR);
    assign start_c      = wr_ctrl_c & bus.writedata[CTRL_START];
    assign timer_zero_c = (timer == '0);
    assign busy_c       = (state != S_IDLE);
    assign done_set_c   = (state == S_HOLD) & timer_zero_c;
    assign fifo_pop_c   = ~fifo_empty &
                          (((state == S_IDLE) & start_c) |
                           ((state == S_HI) & timer_zero_c & (bit_cnt == 3'd0)));
    assign ovf_set_c    = wr_data_c & fifo_full & ~fifo_pop_c;

    nf2401_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data_c),
        .wdata   (bus.writedata),
        .pop     (fifo_pop_c),
        .rdata   (fifo_rdata),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Status word assembly.
    always_comb begin
        stat_c           = '0;
        stat_c[ST_BUSY]  = busy_c;
        stat_c[ST_FULL]  = fifo_full;
        stat_c[ST_EMPTY] = fifo_empty;
        stat_c[ST_DONE]  = done;
        stat_c[ST_OVF]   = ovf;
    end

    // Frame sequencer: CE/CS framing, CLK1 half-period timing and bit shifting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            nrf_ce   <= 1'b0;
            nrf_cs   <= 1'b0;
            nrf_clk1 <= 1'b0;
            nrf_data <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_c && !fifo_empty) begin
                        shift    <= fifo_rdata;
                        nrf_data <= fifo_rdata[7];
                        bit_cnt  <= 3'd7;
                        nrf_ce   <= bus.writedata[CTRL_MODE];
                        nrf_cs   <= ~bus.writedata[CTRL_MODE];
                        timer    <= TW'(SETUP_CYC - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (timer_zero_c) begin
                        timer <= TW'(CLK_HALF - 1);
                        state <= S_LO;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_LO: begin
                    if (timer_zero_c) begin
                        nrf_clk1 <= 1'b1;
                        timer    <= TW'(CLK_HALF - 1);
                        state    <= S_HI;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_HI: begin
                    if (timer_zero_c) begin
                        nrf_clk1 <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            shift    <= {shift[6:0], 1'b0};
                            nrf_data <= shift[6];
                            bit_cnt  <= bit_cnt - 3'd1;
                            timer    <= TW'(CLK_HALF - 1);
                            state    <= S_LO;
                        end else if (!fifo_empty) begin
                            shift    <= fifo_rdata;
                            nrf_data <= fifo_rdata[7];
                            bit_cnt  <= 3'd7;
                            timer    <= TW'(CLK_HALF - 1);
                            state    <= S_LO;
                        end else begin
                            timer <= TW'(HOLD_CYC - 1);
                            state <= S_HOLD;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_HOLD: begin
                    if (timer_zero_c) begin
                        nrf_ce <= 1'b0;
                        nrf_cs <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Control/status registers, interrupt and registered read mux.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode         <= 1'b0;
            irq_en       <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            bus.irq      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_ctrl_c) begin
                mode   <= bus.writedata[CTRL_MODE];
                irq_en <= bus.writedata[CTRL_IRQ_EN];
            end
            if (done_set_c)    done <= 1'b1;
            else if (wr_clr_c) done <= 1'b0;
            if (ovf_set_c)     ovf  <= 1'b1;
            else if (wr_clr_c) ovf  <= 1'b0;
            bus.irq <= done & irq_en;
            case (bus.address)
                ADDR_DATA: bus.readdata <= 8'(fifo_level);
                ADDR_CTRL: bus.readdata <= {5'b0, irq_en, mode, 1'b0};
                ADDR_STAT: bus.readdata <= stat_c;
                default:   bus.readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nf2401_tx_shifter.sv
// Directed bench for nf2401_tx_shifter with short sim timing constants.
module tb_nf2401_tx_shifter;

    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned CLK_HALF   = 2;
    localparam int unsigned SETUP_CYC  = 4;
    localparam int unsigned HOLD_CYC   = 4;

    logic clk;
    logic reset_n;
    logic nrf_ce, nrf_cs, nrf_clk1, nrf_data;

    nf2401_tx_shifter_if bus ();

    nf2401_tx_shifter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_HALF   (CLK_HALF),
        .SETUP_CYC  (SETUP_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .nrf_ce   (nrf_ce),
        .nrf_cs   (nrf_cs),
        .nrf_clk1 (nrf_clk1),
        .nrf_data (nrf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Radio-side observer, sampled on the falling edge.
    int          cyc = 0;
    int          rises = 0;
    int          ce_rises = 0;
    int          cs_rises = 0;
    int          last_fall = 0;
    int          frame_start = 0;
    int          frame_end = 0;
    int          first_gap = 0;
    bit          seen_rise = 1'b0;
    logic [31:0] bits = '0;
    logic        p_ce = 1'b0, p_cs = 1'b0, p_clk1 = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (nrf_clk1 && !p_clk1) begin
            rises = rises + 1;
            bits  = {bits[30:0], nrf_data};
            if (!seen_rise) begin
                first_gap = cyc - frame_start;
                seen_rise = 1'b1;
            end
        end
        if (!nrf_clk1 && p_clk1) last_fall = cyc;
        if ((nrf_ce || nrf_cs) && !(p_ce || p_cs)) begin
            frame_start = cyc;
            seen_rise   = 1'b0;
        end
        if (!(nrf_ce || nrf_cs) && (p_ce || p_cs)) frame_end = cyc;
        if (nrf_ce && !p_ce) ce_rises = ce_rises + 1;
        if (nrf_cs && !p_cs) cs_rises = cs_rises + 1;
        p_ce   = nrf_ce;
        p_cs   = nrf_cs;
        p_clk1 = nrf_clk1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
        @(posedge clk); #1;
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk); #1;
        data           = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    // Poll status until not busy; an expired budget shows up as a busy failure.
    task automatic wait_idle(input string tag);
        logic [7:0] st;
        st = 8'h01;
        for (int i = 0; i < 2000; i++) begin
            bus_read(2'd2, st);
            if (!st[0]) break;
        end
        check(tag, 32'(st[0]), 32'd0);
    endtask

    task automatic wait_rises(input int target, input string tag);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rises >= target) break;
        end
        check(tag, 32'(rises >= target), 32'd1);
    endtask

    logic [7:0] rd;
    int r0, ce0, cs0;

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 8'h00;
        reset_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", 32'(bus.readdata), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_nrf", 32'({nrf_ce, nrf_cs, nrf_clk1, nrf_data}), 32'h0);
        reset_n = 1'b1;
        bus_read(2'd2, rd);
        check("rst_status", 32'(rd), 32'h04);

        // 0xA5 payload frame with irq enabled
        r0 = rises; ce0 = ce_rises; cs0 = cs_rises;
        bus_write(2'd0, 8'hA5);
        bus_write(2'd1, 8'h07);
        wait_idle("a5_idle");
        check("a5_rises", 32'(rises - r0), 32'd8);
        check("a5_bits", 32'(bits[7:0]), 32'hA5);
        check("a5_ce_frames", 32'(ce_rises - ce0), 32'd1);
        check("a5_cs_frames", 32'(cs_rises - cs0), 32'd0);
        check("a5_setup", 32'(first_gap >= int'(SETUP_CYC)), 32'd1);
        check("a5_hold", 32'(frame_end - last_fall), 32'(HOLD_CYC));
        bus_read(2'd2, rd);
        check("a5_status", 32'(rd), 32'h0C);
        check("a5_irq", 32'(bus.irq), 32'd1);
        bus_read(2'd1, rd);
        check("a5_ctrl", 32'(rd), 32'h06);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, rd);
        check("a5_clr_status", 32'(rd), 32'h04);
        check("a5_clr_irq", 32'(bus.irq), 32'd0);

        // Two-byte config frame on CS, irq disabled
        r0 = rises; ce0 = ce_rises; cs0 = cs_rises;
        bus_write(2'd0, 8'h01);
        bus_write(2'd0, 8'h80);
        bus_write(2'd1, 8'h01);
        wait_idle("cs_idle");
        check("cs_rises", 32'(rises - r0), 32'd16);
        check("cs_bits", 32'(bits[15:0]), 32'h0180);
        check("cs_ce_frames", 32'(ce_rises - ce0), 32'd0);
        check("cs_cs_frames", 32'(cs_rises - cs0), 32'd1);
        bus_read(2'd2, rd);
        check("cs_status", 32'(rd), 32'h0C);
        check("cs_irq", 32'(bus.irq), 32'd0);
        bus_write(2'd3, 8'h00);

        // Start with an empty FIFO does nothing
        r0 = rises; ce0 = ce_rises; cs0 = cs_rises;
        bus_write(2'd1, 8'h03);
        repeat (20) @(posedge clk);
        bus_read(2'd2, rd);
        check("empty_status", 32'(rd), 32'h04);
        check("empty_activity", 32'((rises - r0) + (ce_rises - ce0) + (cs_rises - cs0)), 32'd0);

        // Byte pushed mid-frame joins the same frame
        r0 = rises; ce0 = ce_rises;
        bus_write(2'd0, 8'hFF);
        bus_write(2'd1, 8'h03);
        wait_rises(r0 + 4, "join_wait");
        bus_write(2'd0, 8'h00);
        wait_idle("join_idle");
        check("join_rises", 32'(rises - r0), 32'd16);
        check("join_bits", 32'(bits[15:0]), 32'hFF00);
        check("join_frames", 32'(ce_rises - ce0), 32'd1);
        bus_write(2'd3, 8'h00);

        // Overflow: 33 pushes into 32 entries
        for (int i = 0; i < 33; i++) bus_write(2'd0, 8'(i));
        bus_read(2'd0, rd);
        check("ovf_level", 32'(rd), 32'd32);
        bus_read(2'd2, rd);
        check("ovf_status", 32'(rd), 32'h12);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, rd);
        check("ovf_clr_status", 32'(rd), 32'h02);

        // Reset in the middle of a frame
        r0 = rises;
        bus_write(2'd1, 8'h03);
        wait_rises(r0 + 4, "rst_wait");
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_nrf", 32'({nrf_ce, nrf_cs, nrf_clk1, nrf_data}), 32'h0);
        check("mid_rst_readdata", 32'(bus.readdata), 32'h0);
        reset_n = 1'b1;
        r0 = rises;
        bus_read(2'd0, rd);
        check("mid_rst_level", 32'(rd), 32'd0);
        bus_read(2'd2, rd);
        check("mid_rst_status", 32'(rd), 32'h04);
        repeat (10) @(posedge clk);
        check("mid_rst_no_clk1", 32'(rises - r0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
